// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared constants and state codes for the pipeline controller
package pipe_ctrl_pkg;

  localparam logic [31:0] EXC_VECTOR = 32'h0000_0020;

  // Each encoding holds its own stage and every stage upstream of it.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_ALL  = 6'b111111;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_ctrl_wdog.sv
// rtl/pipe_ctrl_wdog.sv - stall watchdog: counts consecutive stalled cycles against a limit
module pipe_ctrl_wdog (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_active,
  input  logic        flush,
  input  logic [15:0] tmo_limit,
  output logic        timeout
);

  logic [15:0] cnt_q, cnt_d;

  // A zero limit disables the watchdog entirely.
  always_comb begin
    timeout = stall_active && (tmo_limit != 16'h0) && (cnt_q == tmo_limit);
  end

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (!stall_active || flush || timeout) begin
      cnt_d = 16'h0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 16'h0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller with watchdog halt and perf counters
import pipe_ctrl_pkg::*;

module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        exc_valid,
  input  logic        exc_is_eret,
  input  logic [31:0] cp0_epc,
  input  logic        cnt_clear,
  input  logic [15:0] tmo_limit,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
);

  state_e      state_q, state_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_count_q, flush_count_d;
  logic        wd_timeout;

  // Outputs are held at zero while reset is asserted, independent of state.
  always_comb begin
    stall  = STALL_NONE;
    flush  = NO_STOP;
    new_pc = 32'h0;
    if (rst) begin
      if (state_q != ST_DRAIN && exc_valid) begin
        flush  = STOP;
        new_pc = exc_is_eret ? cp0_epc : EXC_VECTOR;
      end else if (state_q == ST_HALT) begin
        stall = STALL_ALL;
      end else if (state_q == ST_RUN) begin
        if (stallreq_mem)      stall = STALL_MEM;
        else if (stallreq_ex)  stall = STALL_EX;
        else if (stallreq_id)  stall = STALL_ID;
        else if (stallreq_if)  stall = STALL_IF;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_DRAIN;
    end else if (state_q == ST_DRAIN) begin
      state_d = ST_RUN;
    end else if (wd_timeout) begin
      state_d = ST_HALT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_ctrl_wdog u_wdog (
    .clk          (clk),
    .rst          (rst),
    .stall_active (stall != STALL_NONE),
    .flush        (flush),
    .tmo_limit    (tmo_limit),
    .timeout      (wd_timeout)
  );

  // Clear wins over a same-cycle increment; flush count saturates.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (cnt_clear) begin
      stall_cycles_d = 32'h0;
      flush_count_d  = 16'h0;
    end else begin
      if (stall != STALL_NONE) stall_cycles_d = stall_cycles_q + 32'd1;
      if (flush && flush_count_q != 16'hFFFF) flush_count_d = flush_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= 32'h0;
      flush_count_q  <= 16'h0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_timeout = wd_timeout;
  assign stall_cycles  = stall_cycles_q;
  assign flush_count   = flush_count_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl with behavioural reference model
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_if = 1'b0, stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0;
  logic        exc_valid = 1'b0, exc_is_eret = 1'b0;
  logic [31:0] cp0_epc = 32'h0;
  logic        cnt_clear = 1'b0;
  logic [15:0] tmo_limit = 16'h0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .exc_valid(exc_valid), .exc_is_eret(exc_is_eret), .cp0_epc(cp0_epc),
    .cnt_clear(cnt_clear), .tmo_limit(tmo_limit),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .stall_timeout(stall_timeout), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: mode is 0 running, 1 one-cycle drain, 2 halted.
  localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2;
  int          m_mode = 0;
  logic [15:0] m_wd = 16'h0;
  logic [31:0] m_sc = 32'h0;
  logic [15:0] m_fc = 16'h0;

  function automatic void model_out(output logic [5:0] s, output logic f,
                                    output logic [31:0] pc, output logic to);
    s = 6'h0; f = 1'b0; pc = 32'h0; to = 1'b0;
    if (rst !== 1'b1) return;
    if (m_mode != M_DRAIN && exc_valid) begin
      f  = 1'b1;
      pc = exc_is_eret ? cp0_epc : 32'h20;
    end else if (m_mode == M_HALT) begin
      s = 6'h3F;
    end else if (m_mode == M_RUN) begin
      if (stallreq_mem)      s = 6'b011111;
      else if (stallreq_ex)  s = 6'b001111;
      else if (stallreq_id)  s = 6'b000111;
      else if (stallreq_if)  s = 6'b000011;
    end
    to = (s != 0) && (tmo_limit != 0) && (m_wd == tmo_limit);
  endfunction

  always @(posedge clk or negedge rst) begin : mdl
    logic [5:0]  s;
    logic        f, to;
    logic [31:0] pc;
    if (!rst) begin
      m_mode <= M_RUN;
      m_wd   <= 16'h0;
      m_sc   <= 32'h0;
      m_fc   <= 16'h0;
    end else begin
      model_out(s, f, pc, to);
      if (f) m_mode <= M_DRAIN;
      else if (m_mode == M_DRAIN) m_mode <= M_RUN;
      else if (to) m_mode <= M_HALT;
      m_wd <= (s == 0 || f || to) ? 16'h0 : m_wd + 16'd1;
      m_sc <= cnt_clear ? 32'h0 : ((s != 0) ? m_sc + 32'd1 : m_sc);
      m_fc <= cnt_clear ? 16'h0 : ((f && m_fc != 16'hFFFF) ? m_fc + 16'd1 : m_fc);
    end
  end

  always @(negedge clk) begin : cmp
    logic [5:0]  s;
    logic        f, to;
    logic [31:0] pc;
    model_out(s, f, pc, to);
    chk("m_stall", stall, s);
    chk("m_flush", flush, f);
    chk("m_new_pc", new_pc, pc);
    chk("m_timeout", stall_timeout, to);
    chk("m_stall_cycles", stall_cycles, m_sc);
    chk("m_flush_count", flush_count, m_fc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL sim_time_limit: got expired expected finish");
    $fatal(1);
  end

  initial begin
    int pulses;
    int at;
    stallreq_mem = 1'b1;
    exc_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", stall, 6'h0);
    chk("rst_flush", flush, 1'b0);
    chk("rst_new_pc", new_pc, 32'h0);
    chk("rst_counters", {stall_cycles[15:0], flush_count}, 32'h0);
    tick();
    stallreq_mem = 1'b0; exc_valid = 1'b0; rst = 1'b1;

    stallreq_id = 1'b1; stallreq_mem = 1'b1;
    @(negedge clk);
    chk("prio_mem_over_id", stall, 6'b011111);
    #1 stallreq_mem = 1'b0;
    #1 chk("prio_id_after_drop", stall, 6'b000111);

    tick();
    stallreq_id = 1'b0; stallreq_ex = 1'b1; exc_valid = 1'b1;
    @(negedge clk);
    chk("exc_flush", flush, 1'b1);
    chk("exc_stall", stall, 6'h0);
    chk("exc_vector", new_pc, 32'h0000_0020);
    tick();
    @(negedge clk);
    chk("drain_flush", flush, 1'b0);
    chk("drain_stall", stall, 6'h0);
    tick();
    exc_valid = 1'b0; stallreq_ex = 1'b0;
    @(negedge clk);
    chk("flush_count_one", flush_count, 16'd1);

    tick();
    exc_valid = 1'b1; exc_is_eret = 1'b1; cp0_epc = 32'h8000_0100;
    @(negedge clk);
    chk("eret_pc", new_pc, 32'h8000_0100);
    chk("eret_flush", flush, 1'b1);
    tick();
    exc_valid = 1'b0; exc_is_eret = 1'b0;
    @(negedge clk);
    chk("eret_pc_gone", new_pc, 32'h0);

    tick();
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0; stallreq_ex = 1'b1;
    repeat (10) tick();
    stallreq_ex = 1'b0;
    @(negedge clk);
    chk("stall_cycles_10", stall_cycles, 32'd10);
    chk("flush_count_cleared", flush_count, 16'd0);
    tick();
    stallreq_ex = 1'b1; cnt_clear = 1'b1;
    tick();
    stallreq_ex = 1'b0; cnt_clear = 1'b0;
    @(negedge clk);
    chk("clear_beats_incr", stall_cycles, 32'd0);

    tmo_limit = 16'd5;
    tick();
    stallreq_if = 1'b1;
    pulses = 0; at = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (stall_timeout === 1'b1) begin pulses++; at = k; end
      if (k < 8) tick();
    end
    chk("wdog_pulses", pulses, 1);
    chk("wdog_pulse_cycle", at, 6);
    chk("halt_stall", stall, 6'h3F);
    tick();
    exc_valid = 1'b1;
    @(negedge clk);
    chk("halt_exc_flush", flush, 1'b1);
    chk("halt_exc_stall", stall, 6'h0);
    tick();
    exc_valid = 1'b0;
    @(negedge clk);
    chk("halt_drain_stall", stall, 6'h0);
    tick();
    @(negedge clk);
    chk("back_to_run", stall, 6'b000011);

    repeat (7) tick();
    @(negedge clk);
    chk("halt_again", stall, 6'h3F);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_stall", stall, 6'h0);
    chk("async_rst_timeout", stall_timeout, 1'b0);
    chk("async_rst_flush", flush, 1'b0);
    chk("async_rst_stall_cycles", stall_cycles, 32'h0);
    chk("async_rst_flush_count", flush_count, 16'h0);
    tick();
    rst = 1'b1; stallreq_if = 1'b0;
    tick();
    @(negedge clk);
    chk("post_rst_run", {26'h0, stall} | {31'h0, flush}, 32'h0);

    tick();
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) tmo_limit = 16'($urandom_range(0, 7));
      stallreq_if  = ($urandom_range(0, 3) == 0);
      stallreq_id  = ($urandom_range(0, 3) == 0);
      stallreq_ex  = ($urandom_range(0, 3) == 0);
      stallreq_mem = ($urandom_range(0, 3) == 0);
      exc_valid    = ($urandom_range(0, 24) == 0);
      exc_is_eret  = 1'($urandom_range(0, 1));
      cp0_epc      = $urandom;
      cnt_clear    = ($urandom_range(0, 63) == 0);
      rst          = ($urandom_range(0, 399) != 0);
      tick();
    end
    rst = 1'b1;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
